am2910_seq: RTL and testbench

//  Microprogram sequencer (Am2910 function) that steps the 4-bit ALU slice array.

---
 rtl/am2910_pkg.sv | 27 ++
 rtl/am2910_stack.sv | 52 +++++
 rtl/am2910_seq.sv | 164 ++++++++++++++++
 tb/tb_am2910_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/am2910_pkg.sv
// Shared opcodes and widths for the Am2910-style microprogram sequencer.
// Imported by am2910_stack and am2910_seq.
package am2910_pkg;

  typedef enum logic [3:0] {
    SEQ_JZ   = 4'h0,
    SEQ_CJS  = 4'h1,
    SEQ_JMAP = 4'h2,
    SEQ_CJP  = 4'h3,
    SEQ_PUSH = 4'h4,
    SEQ_JSRP = 4'h5,
    SEQ_CJV  = 4'h6,
    SEQ_JRP  = 4'h7,
    SEQ_RFCT = 4'h8,
    SEQ_RPCT = 4'h9,
    SEQ_CRTN = 4'hA,
    SEQ_CJPP = 4'hB,
    SEQ_LDCT = 4'hC,
    SEQ_LOOP = 4'hD,
    SEQ_CONT = 4'hE,
    SEQ_TWB  = 4'hF
  } seq_op_e;

  localparam int SEQ_AW    = 12;
  localparam int SEQ_DEPTH = 5;

endpackage

// File: rtl/am2910_stack.sv
// Subroutine/loop LIFO: push, pop, clear; top reads pre-edge state.
// Push when full overwrites the top entry; pop when empty holds SP at 0.
module am2910_stack
  import am2910_pkg::*;
#(
  parameter int AW    = SEQ_AW,
  parameter int DEPTH = SEQ_DEPTH,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic           clr_i,
  input  logic [AW-1:0]  din_i,
  output logic [AW-1:0]  top_o,
  output logic [SPW-1:0] sp_o
);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] top_idx;
  logic           full;

  assign full    = (sp_q == SPW'(DEPTH));
  assign top_idx = (sp_q == '0) ? '0 : sp_q - 1'b1;
  assign top_o   = mem_q[top_idx];
  assign sp_o    = sp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (clr_i) begin
      sp_q <= '0;
    end else if (push_i) begin
      if (full) begin
        mem_q[DEPTH-1] <= din_i;
      end else begin
        mem_q[sp_q] <= din_i;
        sp_q        <= sp_q + 1'b1;
      end
    end else if (pop_i) begin
      if (sp_q != '0) begin
        sp_q <= sp_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/am2910_seq.sv
// Am2910-function microprogram sequencer: next-address mux, uPC, R, stack.
// Optional AM2910_SP_DBG_EN adds the sp_dbg output showing the stack pointer.
module am2910_seq
  import am2910_pkg::*;
#(
  parameter int AW    = SEQ_AW,
  parameter int DEPTH = SEQ_DEPTH,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic          cp,
  input  logic          rst,
  input  logic [3:0]    i,
  input  logic [AW-1:0] d,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic          rld_n,
  input  logic          ci,
  input  logic          oe_n,
  output logic [AW-1:0] y,
  output logic          full_n,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n
`ifdef AM2910_SP_DBG_EN
  ,
  output logic [SPW-1:0] sp_dbg
`endif
);

  logic [AW-1:0]  upc_q, upc_d;
  logic [AW-1:0]  r_q, r_d;
  logic [AW-1:0]  y_int;
  logic [AW-1:0]  f;
  logic [SPW-1:0] sp;
  logic           pass, rz;
  logic           push, pop, clr;
  seq_op_e        op;

  assign op    = seq_op_e'(i);
  assign pass  = ccen_n | ~cc_n;
  assign rz    = (r_q == '0);
  assign upc_d = y_int + AW'(ci);

  always_comb begin
    y_int  = upc_q;
    r_d    = r_q;
    push   = 1'b0;
    pop    = 1'b0;
    clr    = 1'b0;
    pl_n   = 1'b0;
    map_n  = 1'b1;
    vect_n = 1'b1;
    unique case (op)
      SEQ_JZ: begin
        y_int = '0;
        clr   = 1'b1;
      end
      SEQ_CJS: begin
        if (pass) y_int = d;
        push = pass;
      end
      SEQ_JMAP: begin
        y_int = d;
        pl_n  = 1'b1;
        map_n = 1'b0;
      end
      SEQ_CJP: if (pass) y_int = d;
      SEQ_PUSH: begin
        push = 1'b1;
        if (pass) r_d = d;
      end
      SEQ_JSRP: begin
        y_int = pass ? d : r_q;
        push  = 1'b1;
      end
      SEQ_CJV: begin
        if (pass) y_int = d;
        pl_n   = 1'b1;
        vect_n = 1'b0;
      end
      SEQ_JRP: y_int = pass ? d : r_q;
      SEQ_RFCT: begin
        if (!rz) begin
          y_int = f;
          r_d   = r_q - 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
      SEQ_RPCT: begin
        if (!rz) begin
          y_int = d;
          r_d   = r_q - 1'b1;
        end
      end
      SEQ_CRTN: begin
        if (pass) y_int = f;
        pop = pass;
      end
      SEQ_CJPP: begin
        if (pass) y_int = d;
        pop = pass;
      end
      SEQ_LDCT: r_d = d;
      SEQ_LOOP: begin
        if (!pass) y_int = f;
        pop = pass;
      end
      SEQ_CONT: ;
      SEQ_TWB: begin
        if (pass) begin
          pop = 1'b1;
        end else if (!rz) begin
          y_int = f;
          r_d   = r_q - 1'b1;
        end else begin
          y_int = d;
          pop   = 1'b1;
        end
      end
    endcase
    // An explicit R load beats any decrement or conditional load.
    if (!rld_n) r_d = d;
    if (rst) begin
      y_int  = '0;
      pl_n   = 1'b0;
      map_n  = 1'b1;
      vect_n = 1'b1;
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
    end
  end

  am2910_stack #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .SPW   (SPW)
  ) u_stack (
    .clk_i  (cp),
    .rst_i  (rst),
    .push_i (push),
    .pop_i  (pop),
    .clr_i  (clr),
    .din_i  (upc_q),
    .top_o  (f),
    .sp_o   (sp)
  );

  assign full_n = (sp != SPW'(DEPTH));
  assign y      = oe_n ? {AW{1'bz}} : y_int;

`ifdef AM2910_SP_DBG_EN
  assign sp_dbg = sp;
`endif

endmodule

// File: tb/tb_am2910_seq.sv
// Vector-table bench for am2910_seq with an expected-output queue.
// Expected values are hand-derived constants in the vector table.
module tb_am2910_seq;
  import am2910_pkg::*;

  logic        cp = 1'b0;
  logic        rst;
  logic [3:0]  i;
  logic [11:0] d;
  logic        cc_n, ccen_n, rld_n, ci, oe_n;
  logic [11:0] y;
  logic        full_n, pl_n, map_n, vect_n;
`ifdef AM2910_SP_DBG_EN
  logic [2:0]  sp_dbg;
`endif

  am2910_seq dut (
    .cp     (cp),
    .rst    (rst),
    .i      (i),
    .d      (d),
    .cc_n   (cc_n),
    .ccen_n (ccen_n),
    .rld_n  (rld_n),
    .ci     (ci),
    .oe_n   (oe_n),
    .y      (y),
    .full_n (full_n),
    .pl_n   (pl_n),
    .map_n  (map_n),
    .vect_n (vect_n)
`ifdef AM2910_SP_DBG_EN
    ,
    .sp_dbg (sp_dbg)
`endif
  );

  always #5 cp = ~cp;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic [11:0] d;
    logic        cc_n, ccen_n, rld_n, ci, oe_n;
    logic [11:0] y;
    logic        full_n;
    logic [2:0]  en;
  } vec_t;

  typedef struct {
    int          idx;
    logic [11:0] y;
    logic        full_n;
    logic [2:0]  en;
    logic        oe_n;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  localparam logic [2:0] EN_PL  = 3'b011;
  localparam logic [2:0] EN_MAP = 3'b101;
  localparam logic [2:0] EN_VEC = 3'b110;

  function automatic void add(
    input logic r, input logic [3:0] op, input logic [11:0] dd,
    input logic c, input logic [11:0] ey,
    input logic ef = 1'b1, input logic [2:0] en = EN_PL,
    input logic ce = 1'b0, input logic rl = 1'b1,
    input logic cci = 1'b1, input logic oe = 1'b0);
    vec_t v;
    v.rst = r; v.op = op; v.d = dd; v.cc_n = c;
    v.ccen_n = ce; v.rld_n = rl; v.ci = cci; v.oe_n = oe;
    v.y = ey; v.full_n = ef; v.en = en;
    tbl.push_back(v);
  endfunction

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (e.oe_n) begin
      if ((|y) === 1'b1) begin
        failures++;
        $display("FAIL v%0d y_hiz got=%h want=zzz", e.idx, y);
      end
    end else if (y !== e.y) begin
      failures++;
      $display("FAIL v%0d y got=%h want=%h", e.idx, y, e.y);
    end
    checks++;
    if (full_n !== e.full_n) begin
      failures++;
      $display("FAIL v%0d full_n got=%b want=%b", e.idx, full_n, e.full_n);
    end
    checks++;
    if ({pl_n, map_n, vect_n} !== e.en) begin
      failures++;
      $display("FAIL v%0d enables got=%b want=%b",
               e.idx, {pl_n, map_n, vect_n}, e.en);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; i = SEQ_CONT; d = '0; cc_n = 1'b1;
    ccen_n = 1'b0; rld_n = 1'b1; ci = 1'b1; oe_n = 1'b0;

    // reset then sequential fetch
    add(1, SEQ_CONT, 12'h000, 1, 12'h000);
    add(0, SEQ_CONT, 12'h000, 1, 12'h000);
    add(0, SEQ_CONT, 12'h000, 1, 12'h001);
    add(0, SEQ_CONT, 12'h000, 1, 12'h002);
    add(0, SEQ_CONT, 12'h000, 1, 12'h003);
    add(0, SEQ_CONT, 12'h000, 1, 12'h004);
    add(0, SEQ_CONT, 12'h000, 1, 12'h005);
    // call / return
    add(0, SEQ_CJS,  12'h100, 0, 12'h100);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h006);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h006);
    // counter loop
    add(0, SEQ_LDCT, 12'h002, 1, 12'h007);
    add(0, SEQ_RPCT, 12'h040, 1, 12'h040);
    add(0, SEQ_RPCT, 12'h040, 1, 12'h040);
    add(0, SEQ_RPCT, 12'h040, 1, 12'h041);
    // stack fill and overflow
    add(0, SEQ_PUSH, 12'h000, 1, 12'h042);
    add(0, SEQ_PUSH, 12'h000, 1, 12'h043);
    add(0, SEQ_PUSH, 12'h000, 1, 12'h044);
    add(0, SEQ_PUSH, 12'h000, 1, 12'h045);
    add(0, SEQ_PUSH, 12'h000, 1, 12'h046, 1);
    add(0, SEQ_PUSH, 12'h000, 1, 12'h047, 0);
    add(0, SEQ_CONT, 12'h000, 1, 12'h048, 0);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h047, 0);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h045, 1);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h044);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h043);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h042);
    add(0, SEQ_CRTN, 12'h000, 1, 12'h043);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h042);
    // three-way branch
    add(0, SEQ_PUSH, 12'h001, 0, 12'h043);
    add(0, SEQ_TWB,  12'h200, 1, 12'h043);
    add(0, SEQ_TWB,  12'h200, 1, 12'h200);
    add(0, SEQ_CONT, 12'h000, 1, 12'h201);
    // source enables, R load override, output enable
    add(0, SEQ_JMAP, 12'h300, 1, 12'h300, 1, EN_MAP);
    add(0, SEQ_CJV,  12'h123, 1, 12'h301, 1, EN_VEC);
    add(0, SEQ_CJV,  12'h123, 0, 12'h123, 1, EN_VEC);
    add(0, SEQ_RFCT, 12'h003, 1, 12'h124, 1, EN_PL, 0, 0);
    add(0, SEQ_RPCT, 12'h050, 1, 12'h050);
    add(0, SEQ_CONT, 12'h000, 1, 12'h051, 1, EN_PL, 0, 1, 1, 1);
    add(0, SEQ_CONT, 12'h000, 1, 12'h052);
    // JZ clears SP only; reset mid-subroutine clears everything
    add(0, SEQ_CJS,  12'h080, 0, 12'h080);
    add(0, SEQ_JZ,   12'h000, 1, 12'h000);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h053);
    add(0, SEQ_CJS,  12'h090, 0, 12'h090);
    add(1, SEQ_JMAP, 12'h300, 1, 12'h000);
    add(0, SEQ_CRTN, 12'h000, 0, 12'h000);
    add(0, SEQ_CONT, 12'h000, 1, 12'h001, 1, EN_PL, 0, 1, 0);
    add(0, SEQ_CONT, 12'h000, 1, 12'h001);
    // remaining opcodes
    add(0, SEQ_JRP,  12'h010, 1, 12'h000);
    add(0, SEQ_JRP,  12'h010, 0, 12'h010);
    add(0, SEQ_JSRP, 12'h020, 1, 12'h000);
    add(0, SEQ_LOOP, 12'h000, 1, 12'h011);
    add(0, SEQ_LOOP, 12'h000, 0, 12'h012);
    add(0, SEQ_CJP,  12'h007, 1, 12'h013);
    add(0, SEQ_CJP,  12'h007, 1, 12'h007, 1, EN_PL, 1);
    add(0, SEQ_CJPP, 12'h009, 0, 12'h009);
    add(0, SEQ_LDCT, 12'h001, 1, 12'h00A);
    add(0, SEQ_PUSH, 12'h000, 1, 12'h00B);
    add(0, SEQ_RFCT, 12'h000, 1, 12'h00B);
    add(0, SEQ_RFCT, 12'h000, 1, 12'h00C);
    add(0, SEQ_TWB,  12'h005, 0, 12'h00D);
    add(0, SEQ_CONT, 12'h000, 1, 12'h00E);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge cp);
      rst = tbl[k].rst; i = tbl[k].op; d = tbl[k].d;
      cc_n = tbl[k].cc_n; ccen_n = tbl[k].ccen_n;
      rld_n = tbl[k].rld_n; ci = tbl[k].ci; oe_n = tbl[k].oe_n;
      e.idx = k; e.y = tbl[k].y; e.full_n = tbl[k].full_n;
      e.en = tbl[k].en; e.oe_n = tbl[k].oe_n;
      sb.push_back(e);
      #2;
      check_out();
    end

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
